// File: rtl/vscale_mp_hasti_sram.sv
// Multi-port HASTI (AHB-lite) SRAM with a one-entry write buffer per port and a
// round-robin commit arbiter. Define HASTI_SRAM_BYPASS_EN to forward buffered
// write data to reads that hit exactly one pending buffer.
module vscale_mp_hasti_sram #(
  parameter  int NPORTS            = 2,
  parameter  int NWORDS            = 1024,
  localparam int HASTI_ADDR_WIDTH  = 32,
  localparam int HASTI_BUS_WIDTH   = 32,
  localparam int HASTI_SIZE_WIDTH  = 3,
  localparam int HASTI_BURST_WIDTH = 3,
  localparam int HASTI_PROT_WIDTH  = 4,
  localparam int HASTI_TRANS_WIDTH = 2,
  localparam int HASTI_RESP_WIDTH  = 1
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [HASTI_ADDR_WIDTH-1:0]  p_haddr     [NPORTS],
  input  logic                         p_hwrite    [NPORTS],
  input  logic [HASTI_SIZE_WIDTH-1:0]  p_hsize     [NPORTS],
  input  logic [HASTI_BURST_WIDTH-1:0] p_hburst    [NPORTS],
  input  logic                         p_hmastlock [NPORTS],
  input  logic [HASTI_PROT_WIDTH-1:0]  p_hprot     [NPORTS],
  input  logic [HASTI_TRANS_WIDTH-1:0] p_htrans    [NPORTS],
  input  logic [HASTI_BUS_WIDTH-1:0]   p_hwdata    [NPORTS],
  output logic [HASTI_BUS_WIDTH-1:0]   p_hrdata    [NPORTS],
  output logic                         p_hready    [NPORTS],
  output logic [HASTI_RESP_WIDTH-1:0]  p_hresp     [NPORTS]
);

  localparam int AW = $clog2(NWORDS);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY = '0;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;

  state_e                       state_q    [NPORTS];
  state_e                       state_d    [NPORTS];
  logic [AW-1:0]                word_q     [NPORTS];
  logic [AW-1:0]                word_d     [NPORTS];
  logic [3:0]                   mask_q     [NPORTS];
  logic [3:0]                   mask_d     [NPORTS];
  logic [NPORTS-1:0]            buf_valid_q;
  logic [NPORTS-1:0]            buf_valid_d;
  logic [AW-1:0]                buf_word_q [NPORTS];
  logic [AW-1:0]                buf_word_d [NPORTS];
  logic [3:0]                   buf_mask_q [NPORTS];
  logic [3:0]                   buf_mask_d [NPORTS];
  logic [HASTI_BUS_WIDTH-1:0]   buf_data_q [NPORTS];
  logic [HASTI_BUS_WIDTH-1:0]   buf_data_d [NPORTS];
  logic [PW-1:0]                ptr_q;
  logic [PW-1:0]                ptr_d;
  logic [HASTI_BUS_WIDTH-1:0]   mem_q      [NWORDS];

  logic [NPORTS-1:0]            gnt;
  logic                         gnt_any;
  logic [PW-1:0]                gnt_idx;
  logic [PW-1:0]                idx;
  int unsigned                  hits;
  logic                         rd_ok;
  logic                         ready;
  logic [HASTI_BUS_WIDTH-1:0]   rd_data;
  logic                         unused_inputs;

  function automatic logic [3:0] byte_mask(input logic [HASTI_SIZE_WIDTH-1:0] size,
                                           input logic [1:0] off);
    logic [3:0] base;
    case (size)
      3'd0:    base = 4'b0001;
      3'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  // Round-robin search starting at ptr_q over ports whose buffer is full.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      idx = PW'((32'(ptr_q) + k) % NPORTS);
      if (!gnt_any && buf_valid_q[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (32'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    hits        = 0;
    rd_ok       = 1'b1;
    ready       = 1'b1;
    rd_data     = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      state_d[i]    = state_q[i];
      word_d[i]     = word_q[i];
      mask_d[i]     = mask_q[i];
      buf_word_d[i] = buf_word_q[i];
      buf_mask_d[i] = buf_mask_q[i];
      buf_data_d[i] = buf_data_q[i];
      p_hrdata[i]   = '0;

      hits    = 0;
      rd_data = mem_q[word_q[i]];
      for (int unsigned j = 0; j < NPORTS; j++) begin
        if (buf_valid_q[j] && buf_word_q[j] == word_q[i]) begin
          hits = hits + 1;
`ifdef HASTI_SRAM_BYPASS_EN
          for (int unsigned b = 0; b < 4; b++)
            if (buf_mask_q[j][b]) rd_data[8*b +: 8] = buf_data_q[j][8*b +: 8];
`endif
        end
      end
`ifdef HASTI_SRAM_BYPASS_EN
      rd_ok = (hits <= 1);
`else
      rd_ok = (hits == 0);
`endif

      case (state_q[i])
        S_RD: begin
          ready       = rd_ok;
          p_hrdata[i] = rd_data;
        end
        S_WR:    ready = !buf_valid_q[i] || gnt[i];
        default: ready = 1'b1;
      endcase
      p_hready[i] = ready;

      // A granted buffer may be refilled on the same edge it commits.
      if (state_q[i] == S_WR && ready) begin
        buf_valid_d[i] = 1'b1;
        buf_word_d[i]  = word_q[i];
        buf_mask_d[i]  = mask_q[i];
        buf_data_d[i]  = p_hwdata[i];
      end else if (gnt[i]) begin
        buf_valid_d[i] = 1'b0;
      end

      if (ready) begin
        if (p_htrans[i][1]) begin
          state_d[i] = p_hwrite[i] ? S_WR : S_RD;
          word_d[i]  = p_haddr[i][AW+1:2];
          mask_d[i]  = byte_mask(p_hsize[i], p_haddr[i][1:0]);
        end else begin
          state_d[i] = S_IDLE;
        end
      end
    end
  end

  always_comb begin
    unused_inputs = 1'b0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      p_hresp[i]    = HASTI_RESP_OKAY;
      unused_inputs = unused_inputs ^ (^{p_haddr[i][HASTI_ADDR_WIDTH-1:AW+2], p_htrans[i][0],
                                         p_hburst[i], p_hprot[i], p_hmastlock[i]});
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ptr_q       <= '0;
      buf_valid_q <= '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        state_q[i]    <= S_IDLE;
        word_q[i]     <= '0;
        mask_q[i]     <= '0;
        buf_word_q[i] <= '0;
        buf_mask_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      buf_valid_q <= buf_valid_d;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        state_q[i]    <= state_d[i];
        word_q[i]     <= word_d[i];
        mask_q[i]     <= mask_d[i];
        buf_word_q[i] <= buf_word_d[i];
        buf_mask_q[i] <= buf_mask_d[i];
        buf_data_q[i] <= buf_data_d[i];
      end
    end
  end

  // Storage is never reset; an empty buffer set under reset blocks any commit.
  always_ff @(posedge hclk) begin
    if (gnt_any) begin
      for (int unsigned b = 0; b < 4; b++)
        if (buf_mask_q[gnt_idx][b])
          mem_q[buf_word_q[gnt_idx]][8*b +: 8] <= buf_data_q[gnt_idx][8*b +: 8];
    end
  end

endmodule

// File: tb/tb_vscale_mp_hasti_sram.sv
// Directed self-checking bench for vscale_mp_hasti_sram with four ports.
module tb_vscale_mp_hasti_sram;
  localparam int NP = 4;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr     [NP];
  logic        hwrite    [NP];
  logic [2:0]  hsize     [NP];
  logic [2:0]  hburst    [NP];
  logic        hmastlock [NP];
  logic [3:0]  hprot     [NP];
  logic [1:0]  htrans    [NP];
  logic [31:0] hwdata    [NP];
  logic [31:0] hrdata    [NP];
  logic        hready    [NP];
  logic [0:0]  hresp     [NP];

  int checks = 0;
  int errors = 0;

  vscale_mp_hasti_sram #(.NPORTS(NP), .NWORDS(1024)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .p_haddr     (haddr),
    .p_hwrite    (hwrite),
    .p_hsize     (hsize),
    .p_hburst    (hburst),
    .p_hmastlock (hmastlock),
    .p_hprot     (hprot),
    .p_htrans    (htrans),
    .p_hwdata    (hwdata),
    .p_hrdata    (hrdata),
    .p_hready    (hready),
    .p_hresp     (hresp)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic ap(input int p, input logic wr, input logic [31:0] a, input logic [2:0] sz);
    htrans[p] = 2'b10;
    hwrite[p] = wr;
    haddr[p]  = a;
    hsize[p]  = sz;
  endtask

  task automatic noap(input int p);
    htrans[p] = 2'b00;
    hwrite[p] = 1'b0;
  endtask

  function automatic logic [31:0] eaddr(input int i, input int n);
    return 32'h100 + i * 32'h40 + n * 4;
  endfunction

  function automatic logic [31:0] edata(input int i, input int n);
    return 32'hC0DE0000 | (i << 8) | n;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ap_n [NP];
    int   dp_n [NP];
    int   stall [NP];
    int   max_stall [NP];
    logic dp_v [NP];
    logic busy;

    for (int p = 0; p < NP; p++) begin
      haddr[p] = '0; hwrite[p] = 1'b0; hsize[p] = 3'd2; hburst[p] = '0;
      hmastlock[p] = 1'b0; hprot[p] = '0; htrans[p] = 2'b00; hwdata[p] = '0;
    end
    hresetn = 1'b1;
    #1 hresetn = 1'b0;
    #1;
    for (int p = 0; p < NP; p++) begin
      chk1("reset_hready", hready[p], 1'b1);
      chk("reset_hrdata", hrdata[p], 32'h0);
      chk1("reset_hresp", hresp[p], 1'b0);
    end
    step; step;
    hresetn = 1'b1;
    step;

    // Own write then back-to-back read of the same word
    ap(0, 1'b1, 32'h10, 3'd2); #1 chk1("A_ap_ready", hready[0], 1'b1); step;
    hwdata[0] = 32'hDEADBEEF; ap(0, 1'b0, 32'h10, 3'd2);
    #1 chk1("A_wr_ready", hready[0], 1'b1); step;
    noap(0); #1;
`ifdef HASTI_SRAM_BYPASS_EN
    chk1("A_rd_ready", hready[0], 1'b1);
    chk("A_rd_data", hrdata[0], 32'hDEADBEEF);
    step;
`else
    chk1("A_rd_stall", hready[0], 1'b0);
    step; #1;
    chk1("A_rd_ready", hready[0], 1'b1);
    chk("A_rd_data", hrdata[0], 32'hDEADBEEF);
    step;
`endif
    #1 chk("A_idle_rdata", hrdata[0], 32'h0);

    // Simultaneous writes on two ports; commit order observed through reads
    hresetn = 1'b0; #1 hresetn = 1'b1; step;
    ap(0, 1'b1, 32'h20, 3'd2); ap(1, 1'b1, 32'h24, 3'd2); step;
    hwdata[0] = 32'h11111111; hwdata[1] = 32'h22222222; noap(0); noap(1);
    #1 chk1("B_p0_ready", hready[0], 1'b1); chk1("B_p1_ready", hready[1], 1'b1);
    step;
    ap(2, 1'b0, 32'h20, 3'd2); ap(3, 1'b0, 32'h24, 3'd2); step;
    noap(2); noap(3); #1;
    chk1("B_p2_ready", hready[2], 1'b1);
    chk("B_p2_data", hrdata[2], 32'h11111111);
`ifdef HASTI_SRAM_BYPASS_EN
    chk1("B_p3_ready", hready[3], 1'b1);
    chk("B_p3_data", hrdata[3], 32'h22222222);
`else
    chk1("B_p3_stall", hready[3], 1'b0);
    step; #1;
    chk1("B_p3_ready", hready[3], 1'b1);
    chk("B_p3_data", hrdata[3], 32'h22222222);
`endif
    step;

    // Byte write into a previously written word
    ap(0, 1'b1, 32'h30, 3'd2); step;
    hwdata[0] = 32'h12345678; noap(0); ap(1, 1'b1, 32'h33, 3'd0); step;
    hwdata[1] = 32'hAB000000; noap(1); #1 chk1("C_p1_ready", hready[1], 1'b1); step;
    ap(2, 1'b0, 32'h30, 3'd2); step;
    noap(2); #1;
    chk1("C_rd_ready", hready[2], 1'b1);
    chk("C_rd_data", hrdata[2], 32'hAB345678);
    step;

    // Read of a word with two pending half-word writes
    ap(0, 1'b1, 32'h40, 3'd1); ap(1, 1'b1, 32'h42, 3'd1); step;
    hwdata[0] = 32'h0000AAAA; hwdata[1] = 32'hBBBB0000; noap(0); noap(1);
    ap(2, 1'b0, 32'h40, 3'd2); step;
    noap(2); #1 chk1("D_two_hit_stall", hready[2], 1'b0); step;
    #1;
`ifdef HASTI_SRAM_BYPASS_EN
    chk1("D_ready", hready[2], 1'b1);
    chk("D_data", hrdata[2], 32'hBBBBAAAA);
`else
    chk1("D_one_hit_stall", hready[2], 1'b0);
    step; #1;
    chk1("D_ready", hready[2], 1'b1);
    chk("D_data", hrdata[2], 32'hBBBBAAAA);
`endif
    step;

    // All ports stream 16 writes each
    for (int p = 0; p < NP; p++) begin
      ap_n[p] = 0; dp_n[p] = 0; stall[p] = 0; max_stall[p] = 0; dp_v[p] = 1'b0;
    end
    busy = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      busy = 1'b0;
      for (int p = 0; p < NP; p++) if (ap_n[p] < 16 || dp_v[p]) busy = 1'b1;
      if (!busy) break;
      for (int p = 0; p < NP; p++) begin
        hwdata[p] = dp_v[p] ? edata(p, dp_n[p]) : 32'h0;
        if (ap_n[p] < 16) ap(p, 1'b1, eaddr(p, ap_n[p]), 3'd2);
        else noap(p);
      end
      #1;
      for (int p = 0; p < NP; p++) begin
        if (hready[p]) begin
          stall[p] = 0;
          dp_v[p]  = (ap_n[p] < 16);
          dp_n[p]  = ap_n[p];
          if (ap_n[p] < 16) ap_n[p]++;
        end else begin
          stall[p]++;
          if (stall[p] > max_stall[p]) max_stall[p] = stall[p];
        end
      end
      step;
    end
    chk1("E_completed", busy, 1'b0);
    for (int p = 0; p < NP; p++) chk1("E_max_stall_le3", max_stall[p] <= 3, 1'b1);
    for (int p = 0; p < NP; p++) noap(p);
    step; step; step; step; step;
    for (int p = 0; p < NP; p++) begin
      for (int n = 0; n < 16; n++) begin
        ap(0, 1'b0, eaddr(p, n), 3'd2); step;
        noap(0); #1 chk("E_mem", hrdata[0], edata(p, n));
      end
    end
    step;

    // Reset between buffer load and commit
    ap(1, 1'b1, 32'h100, 3'd2); step;
    hwdata[1] = 32'h55555555; noap(1); ap(2, 1'b0, 32'h104, 3'd2); step;
    noap(2); #1 chk("F_pre_rdata", hrdata[2], 32'hC0DE0001);
    #1 hresetn = 1'b0;
    #1;
    for (int p = 0; p < NP; p++) begin
      chk1("F_rst_hready", hready[p], 1'b1);
      chk("F_rst_hrdata", hrdata[p], 32'h0);
      chk1("F_rst_hresp", hresp[p], 1'b0);
    end
    step;
    hresetn = 1'b1;
    step;
    ap(0, 1'b0, 32'h100, 3'd2); step;
    noap(0); #1 chk("F_word_kept", hrdata[0], 32'hC0DE0000);
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
